// File: rtl/register_writeback_arbiter_pkg.sv
// Shared types for the register write-back path: word/index/instruction types,
// the write-back nop encoding and the requester payload.
package register_writeback_arbiter_pkg;

  localparam int unsigned word_w                 = 32;
  localparam int unsigned reg_count              = 32;
  localparam int unsigned reg_index_w            = $clog2(reg_count);
  localparam int unsigned num_requesters_default = 3;
  localparam int unsigned requester_index_w      = $clog2(num_requesters_default);

  typedef logic [word_w-1:0]            word_t;
  typedef logic [reg_index_w-1:0]       register_index_t;
  typedef logic [requester_index_w-1:0] requester_index_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ALU  = 4'd1,
    OP_LOAD = 4'd2,
    OP_CSR  = 4'd3,
    OP_MUL  = 4'd4
  } opcode_t;

  typedef struct packed {
    opcode_t         op;
    logic            has_rd;
    register_index_t rd;
    register_index_t rs1;
    register_index_t rs2;
  } instruction_t;

  localparam instruction_t instr_nop = '{op: OP_NOP, has_rd: 1'b0, rd: '0, rs1: '0, rs2: '0};

  typedef struct packed {
    register_index_t rd;
    word_t           data;
  } requester_t;

  // Write-back carrier: a nop that names rd; x0 is marked as having no destination.
  function automatic instruction_t wb_instr_for(register_index_t rd);
    instruction_t i;
    i        = instr_nop;
    i.rd     = rd;
    i.has_rd = (rd != '0);
    return i;
  endfunction

endpackage

// File: rtl/register_writeback_arbiter_round_robin_arbiter.sv
// Combinational round-robin grant: first valid requester at or above ptr, wrapping.
module round_robin_arbiter #(
  parameter int unsigned num_requesters = 3,
  localparam int unsigned idx_w = (num_requesters > 1) ? $clog2(num_requesters) : 1
) (
  input  logic [num_requesters-1:0] valid,
  input  logic [idx_w-1:0]          ptr,
  output logic [num_requesters-1:0] grant_c,
  output logic [idx_w-1:0]          grant_idx_c,
  output logic                      any_grant_c
);

  // Scan from the farthest offset down so the nearest valid requester wins.
  always_comb begin
    int idx;
    idx         = 0;
    grant_c     = '0;
    grant_idx_c = '0;
    any_grant_c = 1'b0;
    for (int k = int'(num_requesters) - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= int'(num_requesters)) idx = idx - int'(num_requesters);
      if (valid[idx_w'(idx)]) begin
        grant_idx_c = idx_w'(idx);
        any_grant_c = 1'b1;
      end
    end
    if (any_grant_c) grant_c[grant_idx_c] = 1'b1;
  end

endmodule

// File: rtl/register_writeback_arbiter.sv
// Round-robin sharing of the register_unit write port with a one-cycle output stage.
// Optional busy-bit hazard scoreboard enabled by WB_ARBITER_SCOREBOARD_EN.
module register_writeback_arbiter
  import register_writeback_arbiter_pkg::*;
#(
  parameter int unsigned num_requesters = num_requesters_default,
  parameter int unsigned size           = reg_count
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic            [num_requesters-1:0] req_valid,
  output logic            [num_requesters-1:0] req_ready,
  input  register_index_t [num_requesters-1:0] req_rd,
  input  word_t           [num_requesters-1:0] req_data,
  output instruction_t                        wb_instr,
  output word_t                               wb_xd,
  output logic                                wb_enable,
  input  logic                                claim_valid,
  input  register_index_t                     claim_rd,
  input  instruction_t                        src_instr,
  output logic                                stall
);

  localparam int unsigned idx_w = (num_requesters > 1) ? $clog2(num_requesters) : 1;

  logic [idx_w-1:0]          rr_ptr;
  logic [num_requesters-1:0] grant_c;
  logic [idx_w-1:0]          grant_idx_c;
  logic                      any_grant_c;
  logic                      handshake_c;
  requester_t                sel_c;

  round_robin_arbiter #(.num_requesters(num_requesters)) u_arb (
    .valid       (req_valid),
    .ptr         (rr_ptr),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c),
    .any_grant_c (any_grant_c)
  );

  // No grants leak out while reset holds the datapath.
  assign req_ready   = reset ? grant_c : '0;
  assign handshake_c = any_grant_c & reset;

  always_comb begin
    sel_c.rd   = req_rd[grant_idx_c];
    sel_c.data = req_data[grant_idx_c];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (handshake_c) begin
      rr_ptr <= (grant_idx_c == idx_w'(num_requesters - 1)) ? '0 : grant_idx_c + idx_w'(1);
    end
  end

  // Registered write stage; wb_xd holds its last value on idle cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_enable <= 1'b0;
      wb_instr  <= instr_nop;
      wb_xd     <= '0;
    end else begin
      wb_enable <= handshake_c;
      if (handshake_c) begin
        wb_instr <= wb_instr_for(sel_c.rd);
        wb_xd    <= sel_c.data;
      end else begin
        wb_instr <= instr_nop;
      end
    end
  end

`ifdef WB_ARBITER_SCOREBOARD_EN
  logic [size-1:0] busy;
  logic [size-1:0] busy_next_c;
  logic            unused_src_c;

  // Clear from the output stage first so a same-index claim overrides it.
  always_comb begin
    busy_next_c = busy;
    if (wb_enable && wb_instr.has_rd) busy_next_c[wb_instr.rd] = 1'b0;
    if (claim_valid && (claim_rd != '0)) busy_next_c[claim_rd] = 1'b1;
    busy_next_c[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= busy_next_c;
  end

  assign stall        = busy[src_instr.rs1] | busy[src_instr.rs2] | busy[src_instr.rd];
  assign unused_src_c = ^{src_instr.op, src_instr.has_rd};
`else
  logic unused_claim_c;

  assign stall          = 1'b0;
  assign unused_claim_c = ^{claim_valid, claim_rd, src_instr};
`endif

endmodule

// File: tb/tb_register_writeback_arbiter.sv
// Randomized and directed bench for register_writeback_arbiter against a queue-free
// behavioural model of round-robin arbitration, the write stage and the busy set.
module tb_register_writeback_arbiter;
  import register_writeback_arbiter_pkg::*;

  localparam int n_req = 3;

  logic                       clk = 1'b0;
  logic                       reset = 1'b0;
  logic [n_req-1:0]           req_valid;
  logic [n_req-1:0]           req_ready;
  register_index_t [n_req-1:0] req_rd;
  word_t [n_req-1:0]          req_data;
  instruction_t               wb_instr;
  word_t                      wb_xd;
  logic                       wb_enable;
  logic                       claim_valid;
  register_index_t            claim_rd;
  instruction_t               src_instr;
  logic                       stall;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference state
  int           m_ptr;
  bit [31:0]    m_busy;
  bit           m_en;
  instruction_t m_instr;
  word_t        m_xd;

  register_writeback_arbiter #(.num_requesters(n_req), .size(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rd      (req_rd),
    .req_data    (req_data),
    .wb_instr    (wb_instr),
    .wb_xd       (wb_xd),
    .wb_enable   (wb_enable),
    .claim_valid (claim_valid),
    .claim_rd    (claim_rd),
    .src_instr   (src_instr),
    .stall       (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [n_req-1:0] v, input int ptr);
    for (int k = 0; k < n_req; k++) begin
      if (v[(ptr + k) % n_req]) return (ptr + k) % n_req;
    end
    return -1;
  endfunction

  function automatic bit exp_stall(input instruction_t s);
`ifdef WB_ARBITER_SCOREBOARD_EN
    return m_busy[s.rs1] | m_busy[s.rs2] | m_busy[s.rd];
`else
    return s.rs1 == 5'd0 && s.rs1 != 5'd0;
`endif
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_busy  = '0;
    m_en    = 1'b0;
    m_instr = instr_nop;
    m_xd    = '0;
  endtask

  // Inputs are set just after a falling edge; one call covers one clock.
  task automatic cycle(input string tag);
    int               g;
    logic [n_req-1:0] exp_ready;
    #1;
    g         = pick(req_valid, m_ptr);
    exp_ready = (g >= 0) ? (n_req'(1) << g) : '0;
    check({tag, ":ready"}, 64'(req_ready), 64'(exp_ready));
    check({tag, ":stall"}, 64'(stall), 64'(exp_stall(src_instr)));
    @(posedge clk);
    if (m_en && m_instr.has_rd) m_busy[m_instr.rd] = 1'b0;
    if (claim_valid && claim_rd != 0) m_busy[claim_rd] = 1'b1;
    m_busy[0] = 1'b0;
    if (g >= 0) begin
      m_en    = 1'b1;
      m_instr = instr_nop;
      m_instr.rd     = req_rd[g];
      m_instr.has_rd = (req_rd[g] != 0);
      m_xd    = req_data[g];
      m_ptr   = (g + 1) % n_req;
    end else begin
      m_en    = 1'b0;
      m_instr = instr_nop;
    end
    #1;
    check({tag, ":wb_enable"}, 64'(wb_enable), 64'(m_en));
    check({tag, ":wb_instr"}, 64'(wb_instr), 64'(m_instr));
    check({tag, ":wb_xd"}, 64'(wb_xd), 64'(m_xd));
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_valid   = '0;
    req_rd      = '0;
    req_data    = '0;
    claim_valid = 1'b0;
    claim_rd    = '0;
    src_instr   = instr_nop;
  endtask

  task automatic set_req(input int i, input register_index_t rd, input word_t data);
    req_valid[i] = 1'b1;
    req_rd[i]    = rd;
    req_data[i]  = data;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    req_valid = '1;
    #12;
    check("reset:ready", 64'(req_ready), 64'(0));
    check("reset:wb_enable", 64'(wb_enable), 64'(0));
    check("reset:wb_instr", 64'(wb_instr), 64'(instr_nop));
    check("reset:wb_xd", 64'(wb_xd), 64'(0));
    check("reset:stall", 64'(stall), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();

    // All three valid for six cycles: rotation 0,1,2,0,1,2
    for (int i = 0; i < n_req; i++) set_req(i, register_index_t'(i + 1), word_t'(32'h100 + i));
    for (int c = 0; c < 6; c++) cycle("rotate");

    idle_inputs();
    cycle("idle_hold");

    set_req(1, 5'd5, 32'h0000_6000);
    cycle("single_r1");
    idle_inputs();

    set_req(2, 5'd0, 32'hFFFF_FFFF);
    cycle("x0_write");
    idle_inputs();
    cycle("idle_after_x0");

    // Claim x9, watch stall across the write-back and a re-claim on the clear edge
    claim_valid = 1'b1;
    claim_rd    = 5'd9;
    src_instr.rs1 = 5'd9;
    cycle("claim9");
    claim_valid = 1'b0;
    cycle("claim9_hold");
    set_req(0, 5'd9, 32'h1234_5678);
    cycle("write9");
    req_valid   = '0;
    claim_valid = 1'b1;
    cycle("reclaim9");
    claim_valid = 1'b0;
    cycle("after_reclaim");
    set_req(0, 5'd9, 32'h0BAD_F00D);
    cycle("write9_again");
    req_valid = '0;
    cycle("clear9");
    cycle("clear9_done");
    idle_inputs();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < n_req; i++) begin
        req_valid[i] = ($urandom_range(0, 99) < 55);
        req_rd[i]    = register_index_t'($urandom_range(0, 31));
        req_data[i]  = word_t'($urandom);
      end
      claim_rd    = register_index_t'($urandom_range(0, 31));
      claim_valid = ($urandom_range(0, 3) == 0) && !m_busy[claim_rd];
      src_instr.rs1 = register_index_t'($urandom_range(0, 31));
      src_instr.rs2 = register_index_t'($urandom_range(0, 31));
      src_instr.rd  = register_index_t'($urandom_range(0, 31));
      cycle("random");
    end
    idle_inputs();

    // Reset asynchronously while a write of x7 sits in the output stage
    set_req(1, 5'd7, 32'hCAFE_0007);
    cycle("pre_reset_r7");
    req_valid = '1;
    reset = 1'b0;
    #1;
    check("midreset:wb_enable", 64'(wb_enable), 64'(0));
    check("midreset:wb_instr", 64'(wb_instr), 64'(instr_nop));
    check("midreset:wb_xd", 64'(wb_xd), 64'(0));
    check("midreset:ready", 64'(req_ready), 64'(0));
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < n_req; i++) set_req(i, register_index_t'(i + 4), word_t'(32'hA0 + i));
    cycle("post_reset_first");
    cycle("post_reset_second");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
